// File: rtl/spi_fnd_receiver.sv
// spi_fnd_receiver
// SPI slave (mode 0, MSB first) that receives 3-byte display frames and
// drives the 4-digit FND controller's value and dot inputs. Committed
// values are held until the next complete frame. MISO returns an ID byte
// followed by the value that was committed before the current frame.
//
// Ports
//   clk          system clock; sclk must be at most clk/8
//   reset        asynchronous, active-high reset
//   i_sclk       SPI clock from the master, asynchronous to clk
//   i_mosi       SPI data from the master
//   i_ss_n       SPI slave select, active low
//   o_miso       SPI data to the master, 1 while deselected
//   o_fnd_data   committed display value, 0..MAX_VALUE
//   o_fnd_dot    committed dot mask
//   o_frame_done one-clk pulse when a frame is committed
//   o_frame_err  one-clk pulse when ss_n rises before 24 bits
//   o_clamped    set when the last commit was clamped to MAX_VALUE
module spi_fnd_receiver #(
    parameter int unsigned MAX_VALUE   = 9999,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  ID_BYTE     = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_sclk,
    input  logic        i_mosi,
    input  logic        i_ss_n,
    output logic        o_miso,
    output logic [13:0] o_fnd_data,
    output logic [3:0]  o_fnd_dot,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic        o_clamped
);

    localparam int unsigned TOP   = SYNC_STAGES - 1;
    localparam logic [13:0] MAX_V = 14'(MAX_VALUE);

    typedef enum logic [1:0] {S_IDLE, S_RX, S_HOLD} state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [SYNC_STAGES-1:0] r_sclkSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic [SYNC_STAGES-1:0] r_ssnSync;
    logic                   r_sclkPrev;
    logic                   r_ssnPrev;

    logic [2:0]  r_bitCnt;
    logic [1:0]  r_byteCnt;
    logic [6:0]  r_rxShift;
    logic [3:0]  r_dot;
    logic [5:0]  r_valueHi;
    logic [7:0]  r_valueLo;
    logic        r_commitPend;
    logic [22:0] r_txShift;
    logic        r_miso;
    logic [13:0] r_fndData;
    logic [3:0]  r_fndDot;
    logic        r_frameDone;
    logic        r_frameErr;
    logic        r_clamped;

    logic        w_sclkRise;
    logic        w_sclkFall;
    logic        w_ssnRise;
    logic        w_ssnFall;
    logic        w_mosiBit;
    logic [7:0]  w_fullByte;
    logic [13:0] w_value;
    logic        w_startFrame;
    logic        w_shift;
    logic        w_byteDone;
    logic        w_lastByte;
    logic        w_shortFrame;
    logic        w_txShift;
    logic        w_endFrame;

    // Synchroniser chains and one detect register per edge-sensitive line.
    // ss_n resets high so that leaving reset never looks like a frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclkSync <= '0;
            r_mosiSync <= '0;
            r_ssnSync  <= '1;
            r_sclkPrev <= 1'b0;
            r_ssnPrev  <= 1'b1;
        end else begin
            r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], i_sclk};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], i_mosi};
            r_ssnSync  <= {r_ssnSync[SYNC_STAGES-2:0], i_ss_n};
            r_sclkPrev <= r_sclkSync[TOP];
            r_ssnPrev  <= r_ssnSync[TOP];
        end
    end

    assign w_sclkRise = r_sclkSync[TOP] & ~r_sclkPrev;
    assign w_sclkFall = ~r_sclkSync[TOP] & r_sclkPrev;
    assign w_ssnRise  = r_ssnSync[TOP] & ~r_ssnPrev;
    assign w_ssnFall  = ~r_ssnSync[TOP] & r_ssnPrev;
    assign w_mosiBit  = r_mosiSync[TOP];
    assign w_fullByte = {r_rxShift, w_mosiBit};
    assign w_value    = {r_valueHi, r_valueLo};

    // Frame state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode and per-clock action strobes for the datapath.
    // A deselect in RX wins over a coincident sclk edge.
    always_comb begin
        w_stateNext  = r_state;
        w_startFrame = 1'b0;
        w_shift      = 1'b0;
        w_byteDone   = 1'b0;
        w_lastByte   = 1'b0;
        w_shortFrame = 1'b0;
        w_txShift    = 1'b0;
        w_endFrame   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ssnFall) begin
                    w_stateNext  = S_RX;
                    w_startFrame = 1'b1;
                end
            end
            S_RX: begin
                if (w_ssnRise) begin
                    w_stateNext  = S_IDLE;
                    w_shortFrame = 1'b1;
                end else if (w_sclkRise) begin
                    w_shift = 1'b1;
                    if (r_bitCnt == 3'd7) begin
                        w_byteDone = 1'b1;
                        if (r_byteCnt == 2'd2) begin
                            w_lastByte  = 1'b1;
                            w_stateNext = S_HOLD;
                        end
                    end
                end else if (w_sclkFall) begin
                    w_txShift = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_ssnRise) begin
                    w_stateNext = S_IDLE;
                    w_endFrame  = 1'b1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Receive shifter, byte storage, MISO shifter and the commit stage.
    // The commit happens the clock after the last bit so the final byte is
    // already registered; the readback snapshot is taken at frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitCnt     <= '0;
            r_byteCnt    <= '0;
            r_rxShift    <= '0;
            r_dot        <= '0;
            r_valueHi    <= '0;
            r_valueLo    <= '0;
            r_commitPend <= 1'b0;
            r_txShift    <= '0;
            r_miso       <= 1'b1;
            r_fndData    <= '0;
            r_fndDot     <= '0;
            r_frameDone  <= 1'b0;
            r_frameErr   <= 1'b0;
            r_clamped    <= 1'b0;
        end else begin
            r_commitPend <= w_lastByte;
            r_frameDone  <= 1'b0;
            r_frameErr   <= w_shortFrame;

            if (w_startFrame) begin
                r_bitCnt  <= '0;
                r_byteCnt <= '0;
                r_txShift <= {ID_BYTE[6:0], 2'b00, r_fndData};
                r_miso    <= ID_BYTE[7];
            end

            if (w_shift) begin
                r_rxShift <= w_fullByte[6:0];
                r_bitCnt  <= r_bitCnt + 3'd1;
            end

            if (w_byteDone) begin
                r_byteCnt <= r_byteCnt + 2'd1;
                case (r_byteCnt)
                    2'd0:    r_dot     <= w_fullByte[3:0];
                    2'd1:    r_valueHi <= w_fullByte[5:0];
                    default: r_valueLo <= w_fullByte;
                endcase
            end

            if (w_txShift) begin
                r_miso    <= r_txShift[22];
                r_txShift <= {r_txShift[21:0], 1'b0};
            end

            if (w_lastByte) begin
                r_miso <= 1'b0;
            end

            if (w_shortFrame || w_endFrame) begin
                r_miso <= 1'b1;
            end

            if (r_commitPend) begin
                r_fndData   <= (w_value > MAX_V) ? MAX_V : w_value;
                r_fndDot    <= r_dot;
                r_clamped   <= (w_value > MAX_V);
                r_frameDone <= 1'b1;
            end
        end
    end

    assign o_miso       = r_miso;
    assign o_fnd_data   = r_fndData;
    assign o_fnd_dot    = r_fndDot;
    assign o_frame_done = r_frameDone;
    assign o_frame_err  = r_frameErr;
    assign o_clamped    = r_clamped;

endmodule

// File: tb/tb_spi_fnd_receiver.sv
// tb_spi_fnd_receiver
// Drives SPI frames at sclk = clk/10 into spi_fnd_receiver. Expected
// commits and short-frame events are queued when a frame is sent; a monitor
// pops and compares whenever the receiver pulses frame_done or frame_err.
// MISO readback and reset values are compared directly by the stimulus.
module tb_spi_fnd_receiver;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_sclk;
    logic        i_mosi;
    logic        i_ss_n;
    logic        o_miso;
    logic [13:0] o_fnd_data;
    logic [3:0]  o_fnd_dot;
    logic        o_frame_done;
    logic        o_frame_err;
    logic        o_clamped;

    typedef struct {
        int data;
        int dot;
        int clamped;
    } exp_t;

    exp_t expQ[$];
    int   errQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    spi_fnd_receiver #(
        .MAX_VALUE  (9999),
        .SYNC_STAGES(2),
        .ID_BYTE    (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_sclk      (i_sclk),
        .i_mosi      (i_mosi),
        .i_ss_n      (i_ss_n),
        .o_miso      (o_miso),
        .o_fnd_data  (o_fnd_data),
        .o_fnd_dot   (o_fnd_dot),
        .o_frame_done(o_frame_done),
        .o_frame_err (o_frame_err),
        .o_clamped   (o_clamped)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Send nBits of data MSB first as an SPI mode-0 master, capturing MISO
    // on each rising sclk. With resetMid set, reset is pulsed after the
    // last bit while ss_n is released, instead of a normal deselect.
    task automatic applyStimulus(input logic [31:0] data, input int nBits,
                                 input bit resetMid, output logic [23:0] rxBits);
        rxBits = '0;
        @(negedge clk);
        i_ss_n = 1'b0;
        for (int i = 0; i < nBits; i++) begin
            i_mosi = data[31-i];
            repeat (HALF) @(negedge clk);
            i_sclk = 1'b1;
            if (i < 24) rxBits[23-i] = o_miso;
            repeat (HALF) @(negedge clk);
            i_sclk = 1'b0;
        end
        if (resetMid) begin
            reset  = 1'b1;
            i_ss_n = 1'b1;
            i_mosi = 1'b0;
            repeat (3) @(negedge clk);
            reset = 1'b0;
        end else begin
            repeat (10) @(negedge clk);
            i_ss_n = 1'b1;
        end
        repeat (20) @(negedge clk);
    endtask

    // Scoreboard monitor: each frame_done pops the next expected commit and
    // each frame_err pops the value that must still be displayed.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_frame_done) begin
                nChecks++;
                if (expQ.size() == 0) begin
                    nFails++;
                    $display("[TB] FAIL frame_done: got a pulse, expected none (data=%0d)", o_fnd_data);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("fnd_data", int'(o_fnd_data), e.data);
                    checkOutput("fnd_dot", int'(o_fnd_dot), e.dot);
                    checkOutput("clamped", int'(o_clamped), e.clamped);
                end
            end
            if (o_frame_err) begin
                nChecks++;
                if (errQ.size() == 0) begin
                    nFails++;
                    $display("[TB] FAIL frame_err: got a pulse, expected none");
                end else begin
                    int held;
                    held = errQ.pop_front();
                    checkOutput("fnd_data held on frame_err", int'(o_fnd_data), held);
                    checkOutput("no frame_done with frame_err", int'(o_frame_done), 0);
                end
            end
        end
    end

    initial begin
        logic [23:0] rx;
        reset  = 1'b1;
        i_sclk = 1'b0;
        i_mosi = 1'b0;
        i_ss_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("reset fnd_data", int'(o_fnd_data), 0);
        checkOutput("reset fnd_dot", int'(o_fnd_dot), 0);
        checkOutput("reset frame_done", int'(o_frame_done), 0);
        checkOutput("reset frame_err", int'(o_frame_err), 0);
        checkOutput("reset clamped", int'(o_clamped), 0);
        checkOutput("reset miso", int'(o_miso), 1);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] frame 05 04 D2");
        expQ.push_back('{1234, 5, 0});
        applyStimulus({8'h05, 8'h04, 8'hD2, 8'h00}, 24, 1'b0, rx);
        checkOutput("miso readback after reset", int'(rx), 24'hA50000);
        checkOutput("miso idle", int'(o_miso), 1);

        $display("[TB] frame 00 3F FF clamps");
        expQ.push_back('{9999, 0, 1});
        applyStimulus({8'h00, 8'h3F, 8'hFF, 8'h00}, 24, 1'b0, rx);
        checkOutput("miso readback 1234", int'(rx), 24'hA504D2);

        $display("[TB] frame 00 00 07 clears clamp");
        expQ.push_back('{7, 0, 0});
        applyStimulus({8'h00, 8'h00, 8'h07, 8'h00}, 24, 1'b0, rx);
        checkOutput("miso readback 9999", int'(rx), 24'hA5270F);

        $display("[TB] short frame keeps 1234");
        expQ.push_back('{1234, 5, 0});
        applyStimulus({8'h05, 8'h04, 8'hD2, 8'h00}, 24, 1'b0, rx);
        errQ.push_back(1234);
        applyStimulus({8'h0F, 8'h3F, 8'hFF, 8'h00}, 12, 1'b0, rx);
        checkOutput("fnd_data after short frame", int'(o_fnd_data), 1234);
        checkOutput("miso after short frame", int'(o_miso), 1);

        $display("[TB] full frame after short frame");
        expQ.push_back('{256, 2, 0});
        applyStimulus({8'h02, 8'h01, 8'h00, 8'h00}, 24, 1'b0, rx);
        checkOutput("miso readback after short frame", int'(rx), 24'hA504D2);

        $display("[TB] 32-bit frame, extra byte ignored");
        expQ.push_back('{42, 15, 0});
        applyStimulus({8'h0F, 8'h00, 8'h2A, 8'hFF}, 32, 1'b0, rx);
        checkOutput("miso readback 256", int'(rx), 24'hA50100);

        $display("[TB] reset during byte 1");
        applyStimulus({8'h03, 8'h12, 8'h34, 8'h00}, 12, 1'b1, rx);
        checkOutput("mid-frame reset fnd_data", int'(o_fnd_data), 0);
        checkOutput("mid-frame reset fnd_dot", int'(o_fnd_dot), 0);
        checkOutput("mid-frame reset clamped", int'(o_clamped), 0);
        checkOutput("mid-frame reset miso", int'(o_miso), 1);

        expQ.push_back('{99, 1, 0});
        applyStimulus({8'h01, 8'h00, 8'h63, 8'h00}, 24, 1'b0, rx);
        checkOutput("miso readback after reset", int'(rx), 24'hA50000);

        repeat (20) @(negedge clk);
        checkOutput("commits still expected", expQ.size(), 0);
        checkOutput("frame errors still expected", errQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
